// File: rtl/race_timer_if.sv
// race_timer_if: groups the race_timer control pulses and display outputs.
//   i_tick    10 Hz one-cycle tick from the divider
//   i_start   begin countdown request
//   i_finish  player completed the text
//   i_abort   return to IDLE from any state
//   o_state   00 IDLE, 01 COUNTDOWN, 10 RUN, 11 DONE
//   o_cd_digit countdown seconds remaining (0 outside COUNTDOWN)
//   o_go      one-cycle pulse on entry to RUN
//   o_min_tens/o_min_ones/o_sec_tens/o_sec_ones/o_tenths  BCD elapsed time
//   o_sat     elapsed time saturated at 99:59.9
interface race_timer_if;
    logic       i_tick;
    logic       i_start;
    logic       i_finish;
    logic       i_abort;
    logic [1:0] o_state;
    logic [3:0] o_cd_digit;
    logic       o_go;
    logic [3:0] o_min_tens;
    logic [3:0] o_min_ones;
    logic [3:0] o_sec_tens;
    logic [3:0] o_sec_ones;
    logic [3:0] o_tenths;
    logic       o_sat;

    modport master (
        output i_tick, i_start, i_finish, i_abort,
        input  o_state, o_cd_digit, o_go, o_min_tens, o_min_ones,
               o_sec_tens, o_sec_ones, o_tenths, o_sat
    );

    modport slave (
        input  i_tick, i_start, i_finish, i_abort,
        output o_state, o_cd_digit, o_go, o_min_tens, o_min_ones,
               o_sec_tens, o_sec_ones, o_tenths, o_sat
    );
endinterface

// File: rtl/race_timer.sv
// race_timer: race start countdown followed by BCD mm:ss.t elapsed-time clock.
// Ports:
//   i_clk  system clock (same as the tick divider)
//   i_rst  asynchronous active-high reset
//   bus    race_timer_if.slave (tick/start/finish/abort in; state, countdown,
//          go pulse, BCD time digits and saturation flag out)
// All outputs are registered.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for start, time held at 0
// S_CD      | counting down COUNTDOWN_SEC seconds, 10 ticks per second
// S_RUN     | counting elapsed time, one tenth per tick
// S_DONE    | finished or saturated, time held until start/abort
module race_timer #(
    parameter int COUNTDOWN_SEC = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    race_timer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CD   = 2'b01,
        S_RUN  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    localparam logic [3:0] CD_INIT = 4'(COUNTDOWN_SEC);

    state_t     r_state, w_state;
    logic [3:0] r_sub, w_sub;
    logic [3:0] r_cd, w_cd;
    logic       r_go, w_go;
    logic [3:0] r_mt, w_mt;
    logic [3:0] r_mo, w_mo;
    logic [3:0] r_st, w_st;
    logic [3:0] r_so, w_so;
    logic [3:0] r_t, w_t;
    logic       r_sat, w_sat;
    logic       w_at_max;

    assign w_at_max = (r_mt == 4'd9) && (r_mo == 4'd9) && (r_st == 4'd5) &&
                      (r_so == 4'd9) && (r_t == 4'd9);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_sub   <= 4'd0;
            r_cd    <= 4'd0;
            r_go    <= 1'b0;
            r_mt    <= 4'd0;
            r_mo    <= 4'd0;
            r_st    <= 4'd0;
            r_so    <= 4'd0;
            r_t     <= 4'd0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_sub   <= w_sub;
            r_cd    <= w_cd;
            r_go    <= w_go;
            r_mt    <= w_mt;
            r_mo    <= w_mo;
            r_st    <= w_st;
            r_so    <= w_so;
            r_t     <= w_t;
            r_sat   <= w_sat;
        end
    end

    always_comb begin
        w_state = r_state;
        w_sub   = r_sub;
        w_cd    = r_cd;
        w_go    = 1'b0;
        w_mt    = r_mt;
        w_mo    = r_mo;
        w_st    = r_st;
        w_so    = r_so;
        w_t     = r_t;
        w_sat   = r_sat;

        if (bus.i_abort) begin
            w_state = S_IDLE;
            w_sub   = 4'd0;
            w_cd    = 4'd0;
            w_mt    = 4'd0;
            w_mo    = 4'd0;
            w_st    = 4'd0;
            w_so    = 4'd0;
            w_t     = 4'd0;
            w_sat   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        w_state = S_CD;
                        w_cd    = CD_INIT;
                        w_sub   = 4'd0;
                    end
                end
                S_CD: begin
                    if (bus.i_tick) begin
                        if (r_sub == 4'd9) begin
                            w_sub = 4'd0;
                            if (r_cd == 4'd1) begin
                                w_state = S_RUN;
                                w_cd    = 4'd0;
                                w_go    = 1'b1;
                            end else begin
                                w_cd = r_cd - 4'd1;
                            end
                        end else begin
                            w_sub = r_sub + 4'd1;
                        end
                    end
                end
                S_RUN: begin
                    // finish outranks a coincident tick: the time is frozen as-is
                    if (bus.i_finish) begin
                        w_state = S_DONE;
                    end else if (bus.i_tick) begin
                        if (w_at_max) begin
                            w_sat   = 1'b1;
                            w_state = S_DONE;
                        end else if (r_t != 4'd9) begin
                            w_t = r_t + 4'd1;
                        end else begin
                            w_t = 4'd0;
                            if (r_so != 4'd9) begin
                                w_so = r_so + 4'd1;
                            end else begin
                                w_so = 4'd0;
                                if (r_st != 4'd5) begin
                                    w_st = r_st + 4'd1;
                                end else begin
                                    w_st = 4'd0;
                                    if (r_mo != 4'd9) begin
                                        w_mo = r_mo + 4'd1;
                                    end else begin
                                        // min_tens cannot pass 9: 99:59.9 is caught above
                                        w_mo = 4'd0;
                                        w_mt = r_mt + 4'd1;
                                    end
                                end
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (bus.i_start) begin
                        w_state = S_CD;
                        w_cd    = CD_INIT;
                        w_sub   = 4'd0;
                        w_mt    = 4'd0;
                        w_mo    = 4'd0;
                        w_st    = 4'd0;
                        w_so    = 4'd0;
                        w_t     = 4'd0;
                        w_sat   = 1'b0;
                    end
                end
                default: w_state = S_IDLE;
            endcase
        end
    end

    assign bus.o_state    = r_state;
    assign bus.o_cd_digit = r_cd;
    assign bus.o_go       = r_go;
    assign bus.o_min_tens = r_mt;
    assign bus.o_min_ones = r_mo;
    assign bus.o_sec_tens = r_st;
    assign bus.o_sec_ones = r_so;
    assign bus.o_tenths   = r_t;
    assign bus.o_sat      = r_sat;

endmodule

// File: tb/tb_race_timer.sv
// tb_race_timer: self-checking bench for race_timer. The reference model keeps
// elapsed time as an integer count of tenths and the countdown as a count of
// ticks since start; display digits are derived from those with arithmetic.
module tb_race_timer;

    localparam int N = 3;
    localparam int ST_IDLE = 0, ST_CD = 1, ST_RUN = 2, ST_DONE = 3;
    localparam int E_MAX = 99 * 600 + 599;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    race_timer_if u_if ();

    race_timer #(.COUNTDOWN_SEC(N)) u_dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (u_if)
    );

    always #5 i_clk = ~i_clk;

    int n_total = 0;
    int n_pass  = 0;

    int m_state = ST_IDLE;
    int m_cdt   = 0;
    int m_e     = 0;
    bit m_sat   = 1'b0;
    bit m_go    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    endtask

    function automatic logic [19:0] exp_time(input int e);
        int mins, secs;
        mins = e / 600;
        secs = (e / 10) % 60;
        return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10), 4'(e % 10)};
    endfunction

    task automatic model_reset();
        m_state = ST_IDLE;
        m_cdt   = 0;
        m_e     = 0;
        m_sat   = 1'b0;
        m_go    = 1'b0;
    endtask

    task automatic model_step(input bit a, input bit f, input bit s, input bit t);
        m_go = 1'b0;
        if (a) begin
            model_reset();
        end else begin
            case (m_state)
                ST_IDLE: if (s) begin m_state = ST_CD; m_cdt = 0; end
                ST_CD: if (t) begin
                    m_cdt++;
                    if (m_cdt == N * 10) begin m_state = ST_RUN; m_go = 1'b1; end
                end
                ST_RUN: begin
                    if (f) m_state = ST_DONE;
                    else if (t) begin
                        if (m_e == E_MAX) begin m_sat = 1'b1; m_state = ST_DONE; end
                        else m_e++;
                    end
                end
                default: if (s) begin m_state = ST_CD; m_cdt = 0; m_e = 0; m_sat = 1'b0; end
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        logic [19:0] got_time;
        int exp_cd;
        got_time = {u_if.o_min_tens, u_if.o_min_ones, u_if.o_sec_tens,
                    u_if.o_sec_ones, u_if.o_tenths};
        exp_cd = (m_state == ST_CD) ? (N - m_cdt / 10) : 0;
        chk({tag, ".state"}, 32'(u_if.o_state), 32'(m_state));
        chk({tag, ".cd"},    32'(u_if.o_cd_digit), 32'(exp_cd));
        chk({tag, ".go"},    32'(u_if.o_go), 32'(m_go));
        chk({tag, ".time"},  32'(got_time), 32'(exp_time(m_e)));
        chk({tag, ".sat"},   32'(u_if.o_sat), 32'(m_sat));
    endtask

    task automatic cyc(input bit a, input bit f, input bit s, input bit t, input string tag);
        @(negedge i_clk);
        u_if.i_abort  = a;
        u_if.i_finish = f;
        u_if.i_start  = s;
        u_if.i_tick   = t;
        @(posedge i_clk);
        model_step(a, f, s, t);
        #1;
        check_all(tag);
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, tag);
    endtask

    // Drives ticks (every cycle or random) until the model reaches tgt, bounded.
    task automatic run_to(input int tgt, input int budget, input bit rnd, input string tag);
        int b;
        b = budget;
        while (m_state != tgt && b > 0) begin
            cyc(0, 0, 0, rnd ? 1'($urandom % 2) : 1'b1, tag);
            b--;
        end
        if (m_state != tgt) chk({tag, ".timeout"}, 32'(u_if.o_state), 32'(tgt));
    endtask

    initial begin
        int b;
        u_if.i_tick = 0; u_if.i_start = 0; u_if.i_finish = 0; u_if.i_abort = 0;
        #2;
        model_reset();
        check_all("reset");
        @(negedge i_clk);
        i_rst = 1'b0;

        ticks(20, "idle_hold");

        // start with coincident tick (not counted), random tick gaps in countdown
        cyc(0, 0, 1, 1, "start1");
        run_to(ST_RUN, 400, 1'b1, "cd_rand");
        b = 400;
        while (m_e != 42 && b > 0) begin
            cyc(0, 0, 0, 1'($urandom % 2), "run_rand");
            b--;
        end
        chk("reach_4_2", 32'(m_e), 32'd42);

        // asynchronous reset mid-run, checked without a clock edge
        i_rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        ticks(20, "idle_after_rst");

        // countdown and run counting with back-to-back ticks
        cyc(0, 0, 1, 0, "start2");
        ticks(9, "cd9");
        ticks(1, "cd10");
        ticks(10, "cd20");
        ticks(9, "cd29");
        ticks(1, "cd30_go");
        ticks(1, "go_drop");
        ticks(124, "run125");
        ticks(475, "run600");

        // finish colliding with tick at 00:07.3
        cyc(1, 0, 0, 0, "abort_a");
        cyc(0, 0, 1, 0, "start3");
        run_to(ST_RUN, 100, 1'b0, "cd3");
        ticks(73, "to_7_3");
        cyc(0, 1, 0, 1, "finish_tick");
        ticks(5, "done_hold");
        cyc(0, 0, 1, 0, "done_restart");

        // abort + start + tick in countdown (cd_digit = 2), then mid-run
        ticks(15, "cd_to_2");
        cyc(1, 0, 1, 1, "abort_cd");
        ticks(3, "after_abort_cd");
        cyc(0, 0, 1, 0, "start4");
        run_to(ST_RUN, 100, 1'b0, "cd4");
        ticks(30, "run30");
        cyc(1, 0, 1, 1, "abort_run");
        ticks(3, "after_abort_run");

        // random mix of all inputs
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom % 200 == 0), 1'($urandom % 80 == 0),
                1'($urandom % 40 == 0), 1'($urandom % 2), "random");
        end

        // saturation
        cyc(1, 0, 0, 0, "abort_s");
        cyc(0, 0, 1, 0, "start_s");
        run_to(ST_RUN, 100, 1'b0, "cd_s");
        run_to(ST_DONE, E_MAX + 100, 1'b0, "run_s");
        chk("sat_flag", 32'(u_if.o_sat), 32'd1);
        ticks(5, "sat_hold");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/race_timer.md
# race_timer

Game-clock stage for TypeRacer, directly downstream of the low-frequency tick divider. It consumes the divider's one-cycle 10 Hz `tick` pulse and runs a race start countdown (N..1 seconds). It then issues a one-cycle `go` pulse and counts elapsed race time as BCD mm:ss.t for the seven-segment display and scoring logic. Timing resolution is one tick (0.1 s).

## Interface
- `COUNTDOWN_SEC`, default 3: countdown length in seconds; legal range 1..9.
- `clk`  input  1  system clock; the same clock drives the tick divider.
- `rst`  input  1  asynchronous, active-high reset.
- `tick`  input  1  one-`clk`-wide pulse, 10 per second, from the upstream divider.
- `start`  input  1  one-cycle request to begin the countdown.
- `finish`  input  1  one-cycle pulse: the player completed the text.
- `abort`  input  1  one-cycle pulse: return to IDLE from any state.
- `state`  output  2  00 IDLE, 01 COUNTDOWN, 10 RUN, 11 DONE.
- `cd_digit`  output  4  countdown seconds remaining; 0 outside COUNTDOWN.
- `go`  output  1  one-cycle pulse on entry to RUN.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`, `tenths`  output  4 each  BCD elapsed time.
- `sat`  output  1  elapsed time saturated at 99:59.9.

## Operation
- All outputs are registered.
- Reset values:
  - `state` = IDLE.
  - All BCD digits, `cd_digit`, `go` and `sat` = 0.
- Input priority in the same cycle: `abort` > `finish` > `start` > `tick`.
- IDLE:
  - Time digits and `sat` are held at 0.
  - `start` → COUNTDOWN, with `cd_digit` = COUNTDOWN_SEC and the internal tick sub-counter `sub` = 0.
- COUNTDOWN:
  - Each `tick` increments `sub` (4-bit, 0..9).
  - On a `tick` with `sub`=9, `sub` returns to 0. Then:
    - If `cd_digit`=1: go to RUN, set `cd_digit` = 0, and assert `go`.
    - Otherwise: decrement `cd_digit`.
  - `start` and `finish` are ignored.
- RUN:
  - Each `tick` increments the BCD time.
  - Carry chain: `tenths` 9→0 carries into `sec_ones`; `sec_ones` 9→0 carries into `sec_tens`; `sec_tens` 5→0 carries into `min_ones`; `min_ones` 9→0 carries into `min_tens`.
  - Each digit is updated only on its carry and never holds a non-BCD value.
  - At 99:59.9, a further `tick` leaves the time unchanged, sets `sat` = 1 and moves to DONE.
  - `finish` → DONE. If `tick` coincides with `finish`, the time is not incremented.
  - `start` is ignored.
- DONE:
  - Time and `sat` hold.
  - `start` → COUNTDOWN. In the same edge, the time digits and `sat` clear to 0, `cd_digit` = COUNTDOWN_SEC and `sub` = 0.
- `abort`, from any state: next state is IDLE, and all outputs return to their reset values on the same edge.
- `go` is high only in the single cycle after the transition edge. It is 0 in every other cycle, including after `abort` or `rst`.

## Timing
- Registered-output latency: an input sampled at edge k is reflected on the outputs after edge k, i.e. visible in cycle k+1.
- Countdown length is exactly COUNTDOWN_SEC×10 ticks after the `start` edge:
  - The first tick counted is the first `tick` sampled after the edge that accepted `start`.
  - A `tick` in the same cycle as `start` is not counted.
- `go` and `state`=RUN appear in the same cycle. The first time increment occurs on the next sampled `tick`, never on the tick that ended the countdown.
- Back-to-back pulses: `tick` may be high in consecutive cycles (bench only); every cycle with `tick`=1 counts once.
- Asynchronous `rst` clears all state immediately, regardless of `clk`; release is synchronised by the system reset scheme.

## Test plan
- Reset and idle hold:
  - Assert `rst` mid-RUN at time 00:04.2 → all outputs 0 and `state`=IDLE without a clock edge.
  - After release, 20 ticks with no `start` → outputs stay 0.
- Countdown, COUNTDOWN_SEC=3:
  - `start` + 9 ticks → `cd_digit`=3; 10th tick → 2; 20th tick → 1.
  - 30th tick → `go`=1 for exactly one cycle, `state`=RUN, `cd_digit`=0, time 00:00.0.
- Run counting:
  - After `go`, 125 ticks → 00:12.5.
  - Continue to 599 total ticks → 00:59.9; one more tick → 01:00.0.
- Finish collision:
  - At 00:07.3, `finish` and `tick` in the same cycle → DONE with 00:07.3.
  - Further ticks → no change.
  - `start` → COUNTDOWN, time 00:00.0, `cd_digit`=3.
- Saturation:
  - Reach 99:59.9; next tick → time 99:59.9, `sat`=1, `state`=DONE.
  - Further ticks → no change.
- Abort priority:
  - During COUNTDOWN (`cd_digit`=2), assert `abort`, `start` and `tick` together → IDLE, all outputs 0, no `go`.
  - Repeat mid-RUN → same result.
